// File: rtl/fifo_word_serializer.sv
// Word-to-beat serializer draining a show-ahead FIFO onto a valid/ready stream, MSB slice first.
// Optional completed-word counter output words_sent is enabled by defining SER_WORD_CNT_EN.
`timescale 1ns/1ps

module fifo_word_serializer #(
  parameter int FIFO_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy
`ifdef SER_WORD_CNT_EN
  ,
  output logic [15:0]           words_sent
`endif
);

  localparam int BEATS = FIFO_WIDTH / OUT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [FIFO_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  accept;
  logic                  last_beat;
  logic                  can_pop;

  assign out_valid = (state_q == SEND);
  assign busy      = out_valid;
  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign out_last  = out_valid && last_beat;
  assign out_data  = out_valid ? shreg_q[FIFO_WIDTH-1 -: OUT_WIDTH] : '0;
  assign accept    = out_valid && out_ready;
  // A pop in the reset cycle would lose the word, since the load is discarded by reset.
  assign can_pop   = !fifo_empty && !reset;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    shreg_d    = shreg_q;
    beat_cnt_d = beat_cnt_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_pop) begin
          fifo_pop   = 1'b1;
          shreg_d    = fifo_data;
          beat_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (!last_beat) begin
            shreg_d    = shreg_q << OUT_WIDTH;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end else if (can_pop) begin
            // Reload on the last-beat accept keeps the link saturated across words.
            fifo_pop   = 1'b1;
            shreg_d    = fifo_data;
            beat_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef SER_WORD_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      words_sent <= '0;
    end else if (accept && last_beat && (words_sent != 16'hFFFF)) begin
      words_sent <= words_sent + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Self-checking bench for fifo_word_serializer: directed scenarios plus randomized traffic
// checked every cycle against a word-level reference model (define SER_WORD_CNT_EN to cover the counter).
`timescale 1ns/1ps

module tb_fifo_word_serializer;

  localparam int FW    = 32;
  localparam int OW    = 8;
  localparam int BEATS = FW / OW;

  logic          clk;
  logic          reset;
  logic          fifo_empty;
  logic [FW-1:0] fifo_data;
  logic          fifo_pop;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;
`ifdef SER_WORD_CNT_EN
  logic [15:0]   words_sent;
`endif

  int errors = 0;
  int checks = 0;

  fifo_word_serializer #(.FIFO_WIDTH(FW), .OUT_WIDTH(OW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
`ifdef SER_WORD_CNT_EN
    ,
    .words_sent (words_sent)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO in front of the DUT (show-ahead: head word always visible).
  logic [FW-1:0] fifo_q[$];

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [FW-1:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  // Inputs change 2 time units after the rising edge; outputs are checked at the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Word-level reference model: word held by the serializer and how many of its beats remain.
  bit            mon_en = 1'b0;
  bit            do_pop = 1'b0;
  int            held   = 0;
  int            words  = 0;
  logic [FW-1:0] cur    = '0;
  bit            acc_e;
  bit            pop_e;
  logic [OW-1:0] exp_beat;

  always @(negedge clk) begin
    if (mon_en) begin
      acc_e = (held > 0) && out_ready;
      pop_e = !fifo_empty && !reset && ((held == 0) || (acc_e && held == 1));
      checks++;
      if (out_valid !== (held > 0)) begin
        errors++;
        $display("FAIL mon_out_valid @%0t: got %b expected %b", $time, out_valid, held > 0);
      end
      checks++;
      if (busy !== (held > 0)) begin
        errors++;
        $display("FAIL mon_busy @%0t: got %b expected %b", $time, busy, held > 0);
      end
      checks++;
      if (fifo_pop !== pop_e) begin
        errors++;
        $display("FAIL mon_fifo_pop @%0t: got %b expected %b", $time, fifo_pop, pop_e);
      end
      if (held > 0) begin
        exp_beat = OW'(cur >> (OW * (held - 1)));
        checks++;
        if (out_data !== exp_beat) begin
          errors++;
          $display("FAIL mon_out_data @%0t: got %h expected %h", $time, out_data, exp_beat);
        end
        checks++;
        if (out_last !== (held == 1)) begin
          errors++;
          $display("FAIL mon_out_last @%0t: got %b expected %b", $time, out_last, held == 1);
        end
      end
`ifdef SER_WORD_CNT_EN
      checks++;
      if (words_sent !== 16'(words)) begin
        errors++;
        $display("FAIL mon_words_sent @%0t: got %0d expected %0d", $time, words_sent, words);
      end
`endif
      if (reset) begin
        held   = 0;
        words  = 0;
        do_pop = 1'b0;
      end else begin
        if (acc_e) begin
          if (held == 1 && words < 65535) words++;
          held--;
        end
        if (pop_e) begin
          cur  = fifo_q[0];
          held = BEATS;
        end
        do_pop = pop_e;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (do_pop && fifo_q.size() != 0) fifo_q.delete(0);
    do_pop = 1'b0;
    refresh();
  end

  task automatic drain(input string name, input int budget);
    int n = 0;
    out_ready = 1'b1;
    while ((fifo_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (fifo_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: fifo words left %0d busy %b after %0d cycles, expected empty and idle",
               name, fifo_q.size(), busy, budget);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b0;
    refresh();
    tick();
    mon_en = 1'b1;
    tick();
    checks++;
    if ({out_valid, busy, fifo_pop, out_last, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b busy=%b pop=%b last=%b data=%h expected all zero",
               out_valid, busy, fifo_pop, out_last, out_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_one_word();
    logic [FW-1:0] w = 32'hA1B2C3D4;
    out_ready = 1'b1;
    push(w);
    #1;
    checks++;
    if (fifo_pop !== 1'b1) begin
      errors++;
      $display("FAIL one_word_pop: got %b expected 1", fifo_pop);
    end
    tick();
    for (int i = 0; i < BEATS; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== OW'(w >> (OW * (BEATS - 1 - i))) ||
          out_last !== (i == BEATS - 1)) begin
        errors++;
        $display("FAIL one_word_beat%0d: got valid=%b data=%h last=%b expected 1 %h %b",
                 i, out_valid, out_data, out_last, OW'(w >> (OW * (BEATS - 1 - i))), i == BEATS - 1);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL one_word_idle: got valid=%b busy=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*FW-1:0] pair = 64'h11223344_55667788;
    out_ready = 1'b1;
    push(pair[2*FW-1:FW]);
    push(pair[FW-1:0]);
    tick();
    for (int i = 0; i < 2 * BEATS; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== OW'(pair >> (OW * (2 * BEATS - 1 - i)))) begin
        errors++;
        $display("FAIL b2b_beat%0d: got valid=%b data=%h expected 1 %h",
                 i, out_valid, out_data, OW'(pair >> (OW * (2 * BEATS - 1 - i))));
      end
      checks++;
      if (fifo_pop !== (i == BEATS - 1)) begin
        errors++;
        $display("FAIL b2b_pop%0d: got %b expected %b", i, fifo_pop, i == BEATS - 1);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    push(32'hDEADBEEF);
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) out_ready = 1'b1;
      #1;
      checks++;
      if (out_data !== 8'hAD || out_valid !== 1'b1 || fifo_pop !== 1'b0 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got data=%h valid=%b pop=%b last=%b expected ad 1 0 0",
                 i, out_data, out_valid, fifo_pop, out_last);
      end
      tick();
    end
    checks++;
    if (out_data !== 8'hBE) begin
      errors++;
      $display("FAIL bp_resume_be: got %h expected be", out_data);
    end
    tick();
    checks++;
    if (out_data !== 8'hEF || out_last !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume_ef: got data=%h last=%b expected ef 1", out_data, out_last);
    end
    tick();
  endtask

  task automatic test_empty_stall();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (fifo_pop !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty_stall%0d: got pop=%b valid=%b expected 0 0", i, fifo_pop, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_word();
    out_ready = 1'b1;
    push(32'hCAFEF00D);
    tick();
    tick();
    tick();
    checks++;
    if (out_data !== 8'hF0) begin
      errors++;
      $display("FAIL rmw_third_beat: got %h expected f0", out_data);
    end
    push(32'h12345678);
    reset = 1'b1;
    #1;
    checks++;
    if (fifo_pop !== 1'b0) begin
      errors++;
      $display("FAIL rmw_no_pop_in_reset: got %b expected 0", fifo_pop);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmw_after_reset: got valid=%b busy=%b expected 0 0", out_valid, busy);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h12) begin
      errors++;
      $display("FAIL rmw_next_word_first_beat: got valid=%b data=%h expected 1 12", out_valid, out_data);
    end
    drain("rmw", 50);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 6) push($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    drain("random", 200);
  endtask

`ifdef SER_WORD_CNT_EN
  task automatic test_word_cnt();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (words_sent !== 16'd0) begin
      errors++;
      $display("FAIL cnt_after_reset: got %0d expected 0", words_sent);
    end
    for (int i = 0; i < 5; i++) push($urandom);
    drain("cnt", 100);
    checks++;
    if (words_sent !== 16'd5) begin
      errors++;
      $display("FAIL cnt_five_words: got %0d expected 5", words_sent);
    end
    push(32'h0BADCAFE);
    tick();
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (words_sent !== 16'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cnt_stalled_word: got count=%0d busy=%b expected 5 1", words_sent, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (words_sent !== 16'd0) begin
      errors++;
      $display("FAIL cnt_cleared: got %0d expected 0", words_sent);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_one_word();
    test_back_to_back();
    test_backpressure();
    test_empty_stall();
    test_reset_mid_word();
    test_random();
`ifdef SER_WORD_CNT_EN
    test_word_cnt();
`endif
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
